// File: rtl/output_byte_ctrl.sv
// Output-byte sequencer for the DES datapath: routes each finished block either to SRAM
// as an 8-beat byte burst with an auto-incrementing write pointer, or to I2C as a valid/ready handoff.
module output_byte_ctrl #(
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          NBYTES    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              des_done_i,
  input  logic              rw_i,
  input  logic              i2c_ready_i,
  input  logic              addr_clear_i,
  output logic              load_enable_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              i2c_valid_o,
  output logic              busy_o,
  output logic              block_done_o,
  output logic              overrun_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    I2C_HOLD,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [2:0]        LAST_BEAT = 3'(NBYTES - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [2:0]          beat_q;
  logic                overrun_q;

  // The chosen direction lives in the state itself: LOAD/WRITE for SRAM, I2C_HOLD for I2C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= BASE;
      beat_q    <= 3'd0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= des_done_i && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (addr_clear_i) ptr_q <= BASE;
          if (des_done_i) state_q <= rw_i ? I2C_HOLD : LOAD;
        end
        LOAD: begin
          beat_q  <= 3'd0;
          state_q <= WRITE;
        end
        WRITE: begin
          ptr_q  <= ptr_q + ADDR_W'(1);
          beat_q <= beat_q + 3'd1;
          if (beat_q == LAST_BEAT) state_q <= DONE;
        end
        I2C_HOLD: begin
          if (i2c_ready_i) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The address bus always shows the write pointer, so it reads BASE_ADDR straight out of reset.
  assign load_enable_o = (state_q == LOAD);
  assign sram_we_o     = (state_q == WRITE);
  assign sram_addr_o   = ptr_q;
  assign i2c_valid_o   = (state_q == I2C_HOLD);
  assign busy_o        = (state_q != IDLE);
  assign block_done_o  = (state_q == DONE);
  assign overrun_o     = overrun_q;

endmodule
